// File: rtl/layer_arb_pkg.sv
// Shared types for the layer-engine share arbiter: FSM states and grant index.
package layer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FWD_IN  = 2'd1,
        FWD_OUT = 2'd2
    } arb_state_t;

    typedef logic grant_t;

    localparam grant_t GRANT_S0 = 1'b0;
    localparam grant_t GRANT_S1 = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; purely combinational, the caller registers the result.
module rr_arb2
    import layer_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last,
    output grant_t     grant
);

    // A lone requester wins outright; on a tie the one not served last wins.
    always_comb begin
        grant = GRANT_S0;
        case (req)
            2'b01:   grant = GRANT_S0;
            2'b10:   grant = GRANT_S1;
            2'b11:   grant = (last == GRANT_S0) ? GRANT_S1 : GRANT_S0;
            default: grant = GRANT_S0;
        endcase
    end

endmodule

// File: rtl/layer_share_arb.sv
// Shares one layer engine between two requesters, one whole vector job at a time:
// N input words are forwarded to the engine, then M result words are routed back.
module layer_share_arb
    import layer_arb_pkg::*;
#(
    parameter int T = 9,
    parameter int N = 5,
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s0_valid,
    input  logic [T-1:0] s0_data,
    output logic         s0_ready,
    input  logic         s1_valid,
    input  logic [T-1:0] s1_data,
    output logic         s1_ready,
    output logic         e_s_valid,
    output logic [T-1:0] e_data_in,
    input  logic         e_s_ready,
    input  logic         e_m_valid,
    input  logic [T-1:0] e_data_out,
    output logic         e_m_ready,
    output logic         m0_valid,
    output logic [T-1:0] m0_data,
    input  logic         m0_ready,
    output logic         m1_valid,
    output logic [T-1:0] m1_data,
    input  logic         m1_ready,
    output logic         owner,
    output logic         busy
);

    localparam int CW = $clog2(max_int(N, M) + 1);
    localparam logic [CW-1:0] IN_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(M - 1);

    arb_state_t    state, state_n;
    grant_t        grant_q, grant_n;
    grant_t        last_grant, last_grant_n;
    grant_t        rr_grant;
    logic [CW-1:0] in_cnt, in_cnt_n;
    logic [CW-1:0] out_cnt, out_cnt_n;
    logic          sel_s_valid;
    logic          sel_m_ready;

    rr_arb2 u_rr (
        .req   ({s1_valid, s0_valid}),
        .last  (last_grant),
        .grant (rr_grant)
    );

    assign sel_s_valid = (grant_q == GRANT_S1) ? s1_valid : s0_valid;
    assign sel_m_ready = (grant_q == GRANT_S1) ? m1_ready : m0_ready;

    assign e_data_in = (grant_q == GRANT_S1) ? s1_data : s0_data;
    assign m0_data   = e_data_out;
    assign m1_data   = e_data_out;
    assign owner     = grant_q;
    assign busy      = (state != IDLE);

    // State, grant and beat counters; last_grant resets to s1 so s0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= GRANT_S0;
            last_grant <= GRANT_S1;
            in_cnt     <= '0;
            out_cnt    <= '0;
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            last_grant <= last_grant_n;
            in_cnt     <= in_cnt_n;
            out_cnt    <= out_cnt_n;
        end
    end

    // Next-state logic and handshake routing; only the owner's side of each stream is connected.
    always_comb begin
        state_n      = state;
        grant_n      = grant_q;
        last_grant_n = last_grant;
        in_cnt_n     = in_cnt;
        out_cnt_n    = out_cnt;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        e_s_valid    = 1'b0;
        e_m_ready    = 1'b0;
        m0_valid     = 1'b0;
        m1_valid     = 1'b0;

        case (state)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    grant_n = rr_grant;
                    state_n = FWD_IN;
                end
            end

            FWD_IN: begin
                e_s_valid = sel_s_valid;
                if (grant_q == GRANT_S1) begin
                    s1_ready = e_s_ready;
                end else begin
                    s0_ready = e_s_ready;
                end
                if (sel_s_valid && e_s_ready) begin
                    if (in_cnt == IN_LAST) begin
                        in_cnt_n = '0;
                        state_n  = FWD_OUT;
                    end else begin
                        in_cnt_n = in_cnt + 1'b1;
                    end
                end
            end

            FWD_OUT: begin
                e_m_ready = sel_m_ready;
                if (grant_q == GRANT_S1) begin
                    m1_valid = e_m_valid;
                end else begin
                    m0_valid = e_m_valid;
                end
                if (e_m_valid && sel_m_ready) begin
                    if (out_cnt == OUT_LAST) begin
                        out_cnt_n    = '0;
                        last_grant_n = grant_q;
                        state_n      = IDLE;
                    end else begin
                        out_cnt_n = out_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/layer_share_arb.md
LAYER_SHARE_ARB -- requirements
Module: layer_share_arb

Interface
REQ-001 Parameter T, default 9, data word width in bits.
REQ-002 Parameter N, default 5, input words per vector (N >= 1).
REQ-003 Parameter M, default 10, output words per vector (M >= 1).
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  reset is asynchronous and active-high.
REQ-006 s0_valid, s0_data[T-1:0]  in  1, T  requester-0 input vector stream; s0_ready  out  1.
REQ-007 s1_valid, s1_data[T-1:0]  in  1, T  requester-1 input vector stream; s1_ready  out  1.
REQ-008 e_s_valid, e_data_in[T-1:0]  out  1, T  engine input stream; e_s_ready  in  1.
REQ-009 e_m_valid, e_data_out[T-1:0]  in  1, T  engine output stream; e_m_ready  out  1.
REQ-010 m0_valid, m0_data[T-1:0]  out  1, T  requester-0 result stream; m0_ready  in  1.
REQ-011 m1_valid, m1_data[T-1:0]  out  1, T  requester-1 result stream; m1_ready  in  1.
REQ-012 owner  out  1  current grant index; busy  out  1  high when the state is not IDLE.

Function
REQ-013 The block SHALL share one layer engine between two requesters at whole-vector granularity, one job in flight at a time.
REQ-014 States SHALL be IDLE, FWD_IN, FWD_OUT.
REQ-015 IDLE: sX_ready=0, e_s_valid=0, e_m_ready=0, m0_valid=m1_valid=0.
REQ-016 IDLE with a request: the registered grant is chosen and the next state is FWD_IN; no beat is accepted in the IDLE cycle.
REQ-017 Round-robin: with one request, grant it; with both, grant the requester not granted last; after reset, s0 wins ties.
REQ-018 FWD_IN: e_s_valid=s<owner>_valid, e_data_in=s<owner>_data, s<owner>_ready=e_s_ready, zero-latency combinational; the non-owner ready SHALL be 0.
REQ-019 in_cnt SHALL count engine-input handshakes 0..N-1; the handshake at N-1 SHALL clear in_cnt and move to FWD_OUT.
REQ-020 FWD_OUT: m<owner>_valid=e_m_valid, m<owner>_data=e_data_out, e_m_ready=m<owner>_ready; the other m valid SHALL be 0.
REQ-021 out_cnt SHALL count result handshakes 0..M-1; the handshake at M-1 SHALL clear out_cnt, record owner as last grant, and return to IDLE.
REQ-022 e_m_ready SHALL be 0 outside FWD_OUT, so early engine output is held by the engine and never dropped.
REQ-023 e_s_valid SHALL be 0 outside FWD_IN.
REQ-024 A new request arriving in the same cycle as the final output handshake SHALL be arbitrated in the following IDLE cycle (exactly one bubble).
REQ-025 A requester deasserting valid mid-vector SHALL stall the job; no timeout, no abort.
REQ-026 Counters SHALL be $clog2(max(N,M)+1) bits wide; counters SHALL not wrap past N-1 or M-1.
REQ-027 When N=1 or M=1, the first handshake in the state SHALL complete that phase.

Reset
REQ-028 Asserting reset at any time, including mid-vector, SHALL immediately force IDLE, in_cnt=0, out_cnt=0, owner=0, and last grant such that s0 wins the next tie.
REQ-029 While reset is high, all valid and ready outputs SHALL be 0 and busy SHALL be 0.
REQ-030 Reset SHALL NOT reset the engine; the integrator resets the engine from the same reset net.

Structure
REQ-031 The state enum and grant index type SHALL live in shared package layer_arb_pkg.
REQ-032 The 2-way round-robin picker SHALL be a sub-module rr_arb2 (req[1:0], last, grant), purely combinational; the FSM SHALL hold the registered grant.
REQ-033 Data paths SHALL be multiplexers only: no buffering and no arithmetic on data.

Verification
REQ-034 s0 only sends 5 words 1..5, engine returns 10 words 0x10..0x19, m0_ready=1 -> m0 receives 0x10..0x19 in order, m1_valid never 1, busy falls 1 cycle after the last beat.
REQ-035 s0 and s1 both valid from reset -> s0 is served first, then s1 (one IDLE bubble between jobs), then s0 on the third job.
REQ-036 m0_ready toggled 1/0 every cycle during FWD_OUT -> e_m_ready mirrors m0_ready and all 10 words arrive with no loss or duplication.
REQ-037 Engine asserts e_m_valid during FWD_IN -> e_m_ready=0 until FWD_OUT, and the first result is delivered only after the 5th input beat.
REQ-038 reset pulsed after the 3rd input beat of s1 -> all ready/valid outputs 0 immediately, state IDLE, and the next job with both requesting grants s0.
REQ-039 s0_valid dropped for 4 cycles after beat 2 -> e_s_valid=0 for those 4 cycles, in_cnt holds at 2, and the job completes normally.
